prefix_decode_stage: RTL

PREFIX_DECODE_STAGE -- requirements
Module: prefix_decode_stage

---
 rtl/prefix_decode_stage.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/prefix_decode_stage.sv
// prefix_decode_stage: scans leading legacy instruction prefixes and registers the decode behind a valid/ready stage.
// Define PREFIX_LOCK_EN to treat F0 (LOCK) as a prefix and drive is_lock; otherwise F0 ends the scan.
module prefix_decode_stage #(
    parameter int unsigned  PKT_W        = 128,
    parameter int unsigned  MAX_PREFIXES = 4,
    localparam int unsigned CNT_W        = $clog2(MAX_PREFIXES + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [PKT_W-1:0] packet,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CNT_W-1:0] num_prefixes,
    output logic             is_rep,
    output logic             is_repne,
    output logic [5:0]       seg_override,
    output logic             is_opsize_override,
    output logic             is_lock,
    output logic             dup_err,
    output logic [PKT_W-1:0] body,
    output logic [15:0]      prefixed_cnt
);

    typedef enum logic [2:0] {
        GRP_NONE,
        GRP_REP,
        GRP_SEG,
        GRP_OPSIZE,
        GRP_LOCK
    } grp_e;

    // Prefix group of a single byte; GRP_NONE terminates the scan.
    function automatic grp_e byte_group(input logic [7:0] b);
        grp_e g;
        g = GRP_NONE;
        case (b)
            8'hF3, 8'hF2:                             g = GRP_REP;
            8'h26, 8'h2E, 8'h36, 8'h3E, 8'h64, 8'h65: g = GRP_SEG;
            8'h66:                                    g = GRP_OPSIZE;
`ifdef PREFIX_LOCK_EN
            8'hF0:                                    g = GRP_LOCK;
`endif
            default:                                  g = GRP_NONE;
        endcase
        return g;
    endfunction

    // One-hot segment select: {GS,FS,DS,SS,CS,ES}.
    function automatic logic [5:0] seg_onehot(input logic [7:0] b);
        logic [5:0] s;
        s = '0;
        case (b)
            8'h26:   s = 6'b000001;
            8'h2E:   s = 6'b000010;
            8'h36:   s = 6'b000100;
            8'h3E:   s = 6'b001000;
            8'h64:   s = 6'b010000;
            8'h65:   s = 6'b100000;
            default: s = '0;
        endcase
        return s;
    endfunction

    logic [7:0]       byte_val [MAX_PREFIXES];
    logic [CNT_W-1:0] num_c;
    logic             rep_c;
    logic             repne_c;
    logic [5:0]       seg_c;
    logic             opsize_c;
    logic             dup_c;
    logic [PKT_W-1:0] body_c;
    logic             accept;
`ifdef PREFIX_LOCK_EN
    logic             lock_c;
`endif

    for (genvar g = 0; g < MAX_PREFIXES; g++) begin : g_byte
        assign byte_val[g] = packet[PKT_W-1-8*g -: 8];
    end

    // In-order scan; later bytes of a group overwrite earlier ones (last wins).
    always_comb begin
        logic scanning;
        logic seen_rep;
        logic seen_seg;
        logic seen_op;
        logic seen_lock;
        grp_e grp;
        scanning  = 1'b1;
        seen_rep  = 1'b0;
        seen_seg  = 1'b0;
        seen_op   = 1'b0;
        seen_lock = 1'b0;
        grp       = GRP_NONE;
        num_c     = '0;
        rep_c     = 1'b0;
        repne_c   = 1'b0;
        seg_c     = '0;
        opsize_c  = 1'b0;
        dup_c     = 1'b0;
`ifdef PREFIX_LOCK_EN
        lock_c    = 1'b0;
`endif
        for (int unsigned i = 0; i < MAX_PREFIXES; i++) begin
            grp = byte_group(byte_val[i]);
            if (!scanning || grp == GRP_NONE) begin
                scanning = 1'b0;
            end else begin
                num_c = CNT_W'(num_c + 1'b1);
                case (grp)
                    GRP_REP: begin
                        dup_c    = dup_c | seen_rep;
                        seen_rep = 1'b1;
                        rep_c    = (byte_val[i] == 8'hF3);
                        repne_c  = (byte_val[i] == 8'hF2);
                    end
                    GRP_SEG: begin
                        dup_c    = dup_c | seen_seg;
                        seen_seg = 1'b1;
                        seg_c    = seg_onehot(byte_val[i]);
                    end
                    GRP_OPSIZE: begin
                        dup_c    = dup_c | seen_op;
                        seen_op  = 1'b1;
                        opsize_c = 1'b1;
                    end
                    GRP_LOCK: begin
                        dup_c     = dup_c | seen_lock;
                        seen_lock = 1'b1;
`ifdef PREFIX_LOCK_EN
                        lock_c    = 1'b1;
`endif
                    end
                    default: begin
                        scanning = 1'b0;
                    end
                endcase
            end
        end
        body_c = packet << {num_c, 3'b000};
    end

    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;

    // Output register: load on accept, drop valid on a consume with no new accept.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_valid          <= 1'b0;
            num_prefixes       <= '0;
            is_rep             <= 1'b0;
            is_repne           <= 1'b0;
            seg_override       <= '0;
            is_opsize_override <= 1'b0;
            dup_err            <= 1'b0;
            body               <= '0;
            prefixed_cnt       <= '0;
        end else if (accept) begin
            out_valid          <= 1'b1;
            num_prefixes       <= num_c;
            is_rep             <= rep_c;
            is_repne           <= repne_c;
            seg_override       <= seg_c;
            is_opsize_override <= opsize_c;
            dup_err            <= dup_c;
            body               <= body_c;
            if (num_c != '0) begin
                prefixed_cnt <= prefixed_cnt + 16'd1;
            end
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

`ifdef PREFIX_LOCK_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            is_lock <= 1'b0;
        end else if (accept) begin
            is_lock <= lock_c;
        end
    end
`else
    assign is_lock = 1'b0;
`endif

endmodule
